multi_cycle_control: RTL

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXEC/MULW/MEM/WB sequencer
// with a multiplier wait counter, a memory handshake and a retired-instruction counter.
module multi_cycle_control #(
  parameter int MUL_LAT = 4,
  parameter bit MEM_HS  = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             funct7_0_i,
  input  logic             mem_ready_i,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       WriteBack,
  output logic             mul_start_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MULW   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t           state, state_next;
  logic [6:0]       op_q;
  logic             f7_q;
  logic [3:0]       wait_q;
  logic [CNT_W-1:0] retire_q;
  logic             retire;
  logic             mem_done;
  logic             opcode_legal;

  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_mul;
  logic [1:0] dec_alu_op, dec_wb;
  logic       dec_src_a, dec_src_b, dec_jump;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write;
  logic       branch, jump, src_a, src_b, mul_start, illegal;
  logic [1:0] alu_op, wb_sel;

  // Without the handshake every memory access completes in its first cycle.
  assign mem_done = (MEM_HS == 1'b0) || mem_ready_i;

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode_i)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    is_r       = (op_q == OP_R);
    is_i       = (op_q == OP_I);
    is_load    = (op_q == OP_LOAD);
    is_store   = (op_q == OP_STORE);
    is_branch  = (op_q == OP_BRANCH);
    is_jal     = (op_q == OP_JAL);
    is_jalr    = (op_q == OP_JALR);
    is_mul     = is_r && f7_q;
    dec_alu_op = is_branch ? 2'b01 : is_r ? 2'b10 : is_i ? 2'b11 : 2'b00;
    dec_src_a  = is_jalr;
    dec_src_b  = is_i || is_load || is_store;
    dec_jump   = is_jal || is_jalr;
    dec_wb     = is_load ? 2'b01 : dec_jump ? 2'b10 : is_mul ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FETCH;
      op_q     <= 7'd0;
      f7_q     <= 1'b0;
      wait_q   <= 4'd0;
      retire_q <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_q <= opcode_i;
        f7_q <= funct7_0_i;
      end
      if (state == EXEC && is_mul) begin
        wait_q <= 4'(MUL_LAT - 1);
      end else if (state == MULW && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (retire) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    src_a      = 1'b0;
    src_b      = 1'b0;
    alu_op     = 2'b00;
    wb_sel     = 2'b00;
    mul_start  = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_done) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Decided from the live opcode, since it is only latched on leaving DECODE.
        if (!opcode_legal) begin
          illegal    = 1'b1;
          pc_write   = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_op = dec_alu_op;
        src_a  = dec_src_a;
        src_b  = dec_src_b;
        jump   = dec_jump;
        branch = is_branch;
        if (is_branch) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else if (is_load || is_store) begin
          state_next = MEM;
        end else if (is_mul) begin
          mul_start  = 1'b1;
          state_next = MULW;
        end else begin
          state_next = WB;
        end
      end
      MULW: begin
        if (wait_q == 4'd0) state_next = WB;
      end
      MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_done) begin
          if (is_store) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        wb_sel     = dec_wb;
        alu_op     = dec_alu_op;
        src_a      = dec_src_a;
        src_b      = dec_src_b;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset forces every output low immediately, not only after the next edge.
  assign PCWrite      = pc_write & ~rst_i;
  assign IRWrite      = ir_write & ~rst_i;
  assign RegWrite     = reg_write & ~rst_i;
  assign MemRead      = mem_read & ~rst_i;
  assign MemWrite     = mem_write & ~rst_i;
  assign Branch       = branch & ~rst_i;
  assign Jump         = jump & ~rst_i;
  assign ALUSrcA      = src_a & ~rst_i;
  assign ALUSrcB      = src_b & ~rst_i;
  assign ALUOp        = rst_i ? 2'b00 : alu_op;
  assign WriteBack    = rst_i ? 2'b00 : wb_sel;
  assign mul_start_o  = mul_start & ~rst_i;
  assign illegal_o    = illegal & ~rst_i;
  assign state_o      = rst_i ? 3'd0 : state;
  assign retire_cnt_o = rst_i ? '0 : retire_q;

endmodule
